// File: rtl/dijkstra_pkg.sv
// Shared constants and FSM encoding for the shortest-path relaxation engine.
// Default widths come from the constants block below so every file agrees.
`ifndef DIJKSTRA_CONSTANTS
`define DIJKSTRA_CONSTANTS
`define DEFAULT_MAX_NODES 4
`define DEFAULT_INDEX_WIDTH 3
`define DEFAULT_VALUE_WIDTH 8
`define UNVISITED 1'b0
`endif

package dijkstra_pkg;

  localparam int DEFAULT_MAX_NODES   = `DEFAULT_MAX_NODES;
  localparam int DEFAULT_INDEX_WIDTH = `DEFAULT_INDEX_WIDTH;
  localparam int DEFAULT_VALUE_WIDTH = `DEFAULT_VALUE_WIDTH;

  localparam logic [DEFAULT_VALUE_WIDTH-1:0] INFINITY = '1;
  localparam logic [DEFAULT_VALUE_WIDTH-1:0] NO_EDGE  = '1;

  localparam logic UNVISITED = `UNVISITED;
  localparam logic VISITED   = ~(`UNVISITED);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_MIN,
    RELAX,
    DONE
  } state_t;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: a + b, clamped to all ones when the sum overflows WIDTH bits.
// Purely combinational, no flow control.
module sat_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign sum      = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];

endmodule

// File: rtl/edge_relaxer.sv
// Dijkstra relaxation engine: walks one adjacency row per selected node, one column per cycle.
// Latency: RELAX takes MAX_NODES+1 cycles per node; waits on min_ready, start ignored while busy.
module edge_relaxer
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [INDEX_WIDTH-1:0]                  source_index,
  input  logic                                    min_ready,
  input  logic [INDEX_WIDTH-1:0]                  sc_min_index,
  input  logic [VALUE_WIDTH-1:0]                  sc_min_value,
  output logic                                    adj_rd_en,
  output logic [INDEX_WIDTH-1:0]                  adj_rd_row,
  output logic [INDEX_WIDTH-1:0]                  adj_rd_col,
  input  logic [VALUE_WIDTH-1:0]                  adj_rd_data,
  output logic [MAX_NODES-1:0][VALUE_WIDTH-1:0]   dist_vector,
  output logic [MAX_NODES-1:0]                    visited_vector,
  output logic [MAX_NODES-1:0][INDEX_WIDTH-1:0]   prev_vector,
  output logic                                    set_en,
  output logic                                    busy,
  output logic                                    done
);

  localparam logic [VALUE_WIDTH-1:0] INF_V     = {VALUE_WIDTH{1'b1}};
  localparam logic [VALUE_WIDTH-1:0] NO_EDGE_V = {VALUE_WIDTH{1'b1}};
  localparam int                     CNT_W     = $clog2(MAX_NODES + 1);
  localparam int                     NW        = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(MAX_NODES);

  state_t                 state_q;
  state_t                 state_d;
  logic [INDEX_WIDTH-1:0] src_q;
  logic [INDEX_WIDTH-1:0] u_q;
  logic [VALUE_WIDTH-1:0] du_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   pend_vld_q;
  logic [INDEX_WIDTH-1:0] pend_col_q;

  logic                   src_ok;
  logic                   min_ok;
  logic                   min_take;
  logic [NW-1:0]          min_idx;
  logic [NW-1:0]          col_idx;
  logic [VALUE_WIDTH-1:0] cand;
  logic                   relax_upd;

  assign src_ok  = int'(src_q) < MAX_NODES;
  assign min_idx = NW'(sc_min_index);
  assign col_idx = NW'(pend_col_q);

  // The selector result is only trusted once set_en has dropped, so it reflects the latest vectors.
  assign min_ok   = min_ready && !set_en;
  assign min_take = min_ok
                 && (sc_min_value != INF_V)
                 && (int'(sc_min_index) < MAX_NODES)
                 && (visited_vector[min_idx] == UNVISITED);

  sat_add #(
    .WIDTH(VALUE_WIDTH)
  ) u_sat_add (
    .a  (du_q),
    .b  (adj_rd_data),
    .sum(cand)
  );

  // Strict less-than keeps the existing predecessor on equal-cost paths.
  assign relax_upd = (state_q == RELAX)
                  && pend_vld_q
                  && (adj_rd_data != NO_EDGE_V)
                  && (visited_vector[col_idx] == UNVISITED)
                  && (cand < dist_vector[col_idx]);

  assign busy       = (state_q == INIT) || (state_q == WAIT_MIN) || (state_q == RELAX);
  assign done       = (state_q == DONE);
  assign adj_rd_en  = (state_q == RELAX) && (cnt_q != LAST_CNT);
  assign adj_rd_row = adj_rd_en ? u_q : '0;
  assign adj_rd_col = adj_rd_en ? INDEX_WIDTH'(cnt_q) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = INIT;
      INIT:       state_d = src_ok ? WAIT_MIN : DONE;
      WAIT_MIN:   if (min_ok) state_d = min_take ? RELAX : DONE;
      RELAX:      if (cnt_q == LAST_CNT) state_d = WAIT_MIN;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      src_q          <= '0;
      u_q            <= '0;
      du_q           <= '0;
      cnt_q          <= '0;
      pend_vld_q     <= 1'b0;
      pend_col_q     <= '0;
      set_en         <= 1'b0;
      dist_vector    <= {MAX_NODES{INF_V}};
      visited_vector <= {MAX_NODES{UNVISITED}};
      prev_vector    <= '0;
    end else begin
      state_q    <= state_d;
      set_en     <= 1'b0;
      pend_vld_q <= adj_rd_en;
      pend_col_q <= INDEX_WIDTH'(cnt_q);
      case (state_q)
        IDLE, DONE: begin
          if (start) src_q <= source_index;
        end
        INIT: begin
          // An out-of-range source still clears the vectors, just without a zero entry.
          for (int i = 0; i < MAX_NODES; i++) begin
            dist_vector[i]    <= (src_ok && (src_q == INDEX_WIDTH'(i))) ? '0 : INF_V;
            visited_vector[i] <= UNVISITED;
            prev_vector[i]    <= src_q;
          end
          set_en <= 1'b1;
        end
        WAIT_MIN: begin
          if (min_take) begin
            u_q                     <= sc_min_index;
            du_q                    <= sc_min_value;
            visited_vector[min_idx] <= VISITED;
            cnt_q                   <= '0;
          end
        end
        RELAX: begin
          if (cnt_q != LAST_CNT) cnt_q <= cnt_q + CNT_W'(1);
          else                   set_en <= 1'b1;
          if (relax_upd) begin
            dist_vector[col_idx] <= cand;
            prev_vector[col_idx] <= u_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_relaxer.sv
// Directed bench for edge_relaxer with a behavioural adjacency RAM and min-selector.
// Each task builds a small graph, runs it, and checks hand-computed results.
module tb_edge_relaxer;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int VW = 8;

  logic                 clock;
  logic                 reset;
  logic                 start;
  logic [IW-1:0]        source_index;
  logic                 min_ready;
  logic [IW-1:0]        sc_min_index;
  logic [VW-1:0]        sc_min_value;
  logic                 adj_rd_en;
  logic [IW-1:0]        adj_rd_row;
  logic [IW-1:0]        adj_rd_col;
  logic [VW-1:0]        adj_rd_data;
  logic [N-1:0][VW-1:0] dist_vector;
  logic [N-1:0]         visited_vector;
  logic [N-1:0][IW-1:0] prev_vector;
  logic                 set_en;
  logic                 busy;
  logic                 done;

  int compared = 0;
  int mismatched = 0;
  int passes = 0;
  int reads = 0;
  int set_pulses = 0;

  logic [VW-1:0] adj [N][N];

  edge_relaxer #(
    .MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .source_index(source_index),
    .min_ready(min_ready), .sc_min_index(sc_min_index), .sc_min_value(sc_min_value),
    .adj_rd_en(adj_rd_en), .adj_rd_row(adj_rd_row), .adj_rd_col(adj_rd_col),
    .adj_rd_data(adj_rd_data), .dist_vector(dist_vector), .visited_vector(visited_vector),
    .prev_vector(prev_vector), .set_en(set_en), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Adjacency RAM with one cycle read latency.
  initial adj_rd_data = 8'hFF;
  always @(posedge clock) begin
    if (adj_rd_en) adj_rd_data <= adj[adj_rd_row[1:0]][adj_rd_col[1:0]];
  end

  // Min-selector: closest unvisited finite node, lowest index on ties.
  always_comb begin
    sc_min_value = 8'hFF;
    sc_min_index = '0;
    for (int i = 0; i < N; i++) begin
      if (!visited_vector[i] && dist_vector[i] < sc_min_value) begin
        sc_min_value = dist_vector[i];
        sc_min_index = IW'(i);
      end
    end
  end

  always @(negedge clock) begin
    if (adj_rd_en) reads++;
    if (adj_rd_en && adj_rd_col == 3'd0) passes++;
    if (set_en) set_pulses++;
  end

  task automatic clear_graph();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        adj[r][c] = 8'hFF;
  endtask

  task automatic add_edge(input int a, input int b, input logic [VW-1:0] w);
    adj[a][b] = w;
    adj[b][a] = w;
  endtask

  task automatic graph_main();
    clear_graph();
    add_edge(0, 1, 8'd5);
    add_edge(0, 2, 8'd1);
    add_edge(2, 1, 8'd2);
    add_edge(1, 3, 8'd1);
  endtask

  task automatic pulse_start(input logic [IW-1:0] src);
    @(negedge clock);
    start = 1'b1;
    source_index = src;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_relax(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (adj_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
    compared++; if (set_en !== 1'b0) begin mismatched++; $display("FAIL reset_set_en got %b want 0", set_en); end
    compared++; if (adj_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en got %b want 0", adj_rd_en); end
    compared++; if (dist_vector !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL reset_dist got %h want ffffffff", dist_vector); end
    compared++; if (visited_vector !== 4'h0) begin mismatched++; $display("FAIL reset_visited got %h want 0", visited_vector); end
    compared++; if (prev_vector !== 12'h000) begin mismatched++; $display("FAIL reset_prev got %h want 000", prev_vector); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [VW-1:0] exp_d [N] = '{8'd0, 8'd3, 8'd1, 8'd4};
    logic [IW-1:0] exp_p [N] = '{3'd0, 3'd2, 3'd0, 3'd1};
    int  p0 = passes;
    int  s0 = set_pulses;
    bit  ok;
    graph_main();
    pulse_start(3'd0);
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL basic_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d[i]) begin mismatched++; $display("FAIL basic_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d[i]); end
      compared++; if (prev_vector[i] !== exp_p[i]) begin mismatched++; $display("FAIL basic_prev[%0d] got %0d want %0d", i, prev_vector[i], exp_p[i]); end
    end
    compared++; if (passes - p0 !== 4) begin mismatched++; $display("FAIL basic_passes got %0d want 4", passes - p0); end
    compared++; if (set_pulses - s0 !== 5) begin mismatched++; $display("FAIL basic_set_en got %0d want 5", set_pulses - s0); end
    compared++; if (visited_vector !== 4'hF) begin mismatched++; $display("FAIL basic_visited got %h want f", visited_vector); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_isolated();
    logic [VW-1:0] exp_d [N] = '{8'd0, 8'd3, 8'd1, 8'hFF};
    logic [IW-1:0] exp_p [N] = '{3'd0, 3'd2, 3'd0, 3'd0};
    int  p0 = passes;
    bit  ok;
    graph_main();
    add_edge(1, 3, 8'hFF);
    pulse_start(3'd0);
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL iso_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d[i]) begin mismatched++; $display("FAIL iso_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d[i]); end
      compared++; if (prev_vector[i] !== exp_p[i]) begin mismatched++; $display("FAIL iso_prev[%0d] got %0d want %0d", i, prev_vector[i], exp_p[i]); end
    end
    compared++; if (passes - p0 !== 3) begin mismatched++; $display("FAIL iso_passes got %0d want 3", passes - p0); end
    compared++; if (visited_vector !== 4'h7) begin mismatched++; $display("FAIL iso_visited got %h want 7", visited_vector); end
  endtask

  task automatic test_tie();
    logic [VW-1:0] exp_d [N] = '{8'd0, 8'd2, 8'd1, 8'hFF};
    bit ok;
    clear_graph();
    add_edge(0, 1, 8'd2);
    add_edge(0, 2, 8'd1);
    add_edge(2, 1, 8'd1);
    pulse_start(3'd0);
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL tie_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d[i]) begin mismatched++; $display("FAIL tie_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d[i]); end
    end
    compared++; if (prev_vector[1] !== 3'd0) begin mismatched++; $display("FAIL tie_prev1 got %0d want 0", prev_vector[1]); end
  endtask

  task automatic test_saturate();
    logic [VW-1:0] exp_d [N] = '{8'd0, 8'd250, 8'hFF, 8'd254};
    logic [IW-1:0] exp_p [N] = '{3'd0, 3'd0, 3'd0, 3'd1};
    bit ok;
    clear_graph();
    add_edge(0, 1, 8'd250);
    add_edge(1, 2, 8'd10);
    add_edge(1, 3, 8'd4);
    pulse_start(3'd0);
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL sat_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d[i]) begin mismatched++; $display("FAIL sat_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d[i]); end
      compared++; if (prev_vector[i] !== exp_p[i]) begin mismatched++; $display("FAIL sat_prev[%0d] got %0d want %0d", i, prev_vector[i], exp_p[i]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [VW-1:0] exp_d  [N] = '{8'd0, 8'd3, 8'd1, 8'd4};
    logic [IW-1:0] exp_p  [N] = '{3'd0, 3'd2, 3'd0, 3'd1};
    logic [VW-1:0] exp_d3 [N] = '{8'd4, 8'd1, 8'd3, 8'd0};
    logic [IW-1:0] exp_p3 [N] = '{3'd2, 3'd3, 3'd1, 3'd3};
    bit ok;
    graph_main();
    pulse_start(3'd0);
    wait_relax(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL ign_relax_timeout rd_en=%b want 1", adj_rd_en); end
    start = 1'b1;
    source_index = 3'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL ign_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d[i]) begin mismatched++; $display("FAIL ign_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d[i]); end
      compared++; if (prev_vector[i] !== exp_p[i]) begin mismatched++; $display("FAIL ign_prev[%0d] got %0d want %0d", i, prev_vector[i], exp_p[i]); end
    end
    pulse_start(3'd3);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_busy got %b want 1", busy); end
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL restart_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d3[i]) begin mismatched++; $display("FAIL restart_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d3[i]); end
      compared++; if (prev_vector[i] !== exp_p3[i]) begin mismatched++; $display("FAIL restart_prev[%0d] got %0d want %0d", i, prev_vector[i], exp_p3[i]); end
    end
  endtask

  task automatic test_bad_source();
    int r0 = reads;
    graph_main();
    pulse_start(3'd5);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL bad_done_early got %b want 0", done); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL bad_busy_init got %b want 1", busy); end
    @(negedge clock);
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL bad_done got %b want 1", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bad_busy got %b want 0", busy); end
    compared++; if (dist_vector !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL bad_dist got %h want ffffffff", dist_vector); end
    compared++; if (visited_vector !== 4'h0) begin mismatched++; $display("FAIL bad_visited got %h want 0", visited_vector); end
    repeat (3) @(negedge clock);
    compared++; if (reads - r0 !== 0) begin mismatched++; $display("FAIL bad_reads got %0d want 0", reads - r0); end
  endtask

  task automatic test_reset_mid_run();
    logic [VW-1:0] exp_d [N] = '{8'd0, 8'd3, 8'd1, 8'd4};
    int p0;
    bit ok;
    graph_main();
    pulse_start(3'd0);
    wait_relax(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL mid_relax_timeout rd_en=%b want 1", adj_rd_en); end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    compared++; if (adj_rd_en !== 1'b0) begin mismatched++; $display("FAIL mid_rd_en got %b want 0", adj_rd_en); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL mid_done got %b want 0", done); end
    compared++; if (set_en !== 1'b0) begin mismatched++; $display("FAIL mid_set_en got %b want 0", set_en); end
    compared++; if ({adj_rd_row, adj_rd_col} !== 6'd0) begin mismatched++; $display("FAIL mid_addr got %h want 0", {adj_rd_row, adj_rd_col}); end
    compared++; if (dist_vector !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mid_dist got %h want ffffffff", dist_vector); end
    compared++; if (visited_vector !== 4'h0) begin mismatched++; $display("FAIL mid_visited got %h want 0", visited_vector); end
    compared++; if (prev_vector !== 12'h000) begin mismatched++; $display("FAIL mid_prev got %h want 000", prev_vector); end
    @(negedge clock);
    reset = 1'b1;
    p0 = passes;
    pulse_start(3'd0);
    wait_done(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL post_timeout done=%b want 1", done); end
    for (int i = 0; i < N; i++) begin
      compared++; if (dist_vector[i] !== exp_d[i]) begin mismatched++; $display("FAIL post_dist[%0d] got %0d want %0d", i, dist_vector[i], exp_d[i]); end
    end
    compared++; if (passes - p0 !== 4) begin mismatched++; $display("FAIL post_passes got %0d want 4", passes - p0); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    source_index = '0;
    min_ready = 1'b1;
    clear_graph();
    test_reset();
    test_basic();
    test_isolated();
    test_tie();
    test_saturate();
    test_start_ignored();
    test_bad_source();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
